// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
//   Shared definitions for the AXI4-Lite register slave: response codes,
//   write/read handshake FSM encodings and the register index width helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Number of address bits needed to select one of n registers.
  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank
//   Register storage for the AXI4-Lite slave: one byte-strobed write port,
//   one combinational read port and a flat view of every register.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset (clears all regs)
//   we, widx, wdata, wstrb write enable, register index, data, byte enables
//   ridx, rdata           read index and the selected register value
//   regs_out              live contents, reg k at [32k+31:32k]
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = idx_width(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           we,
  input  logic [IDX_W-1:0]               widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [3:0]                     wstrb,
  input  logic [IDX_W-1:0]               ridx,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          q_reg <= '0;
        end else if (we && (widx == IDX_W'(gi))) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
              q_reg[8*b +: 8] <= wdata[8*b +: 8];
            end
          end
        end
      end

      assign mem[gi] = q_reg;
      assign regs_out[DATA_WIDTH*gi +: DATA_WIDTH] = q_reg;
    end
  endgenerate

  // Read sees the value before any write committing on the same edge.
  assign rdata = mem[ridx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs
//   AXI4-Lite slave terminating one address window [BASE_ADDR, BASE_ADDR+4*NUM_REGS).
//   Independent write (AW/W -> B) and read (AR -> R) engines; all readies,
//   valids and response fields are registered.
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel
//   bresp/bvalid/bready              write response channel
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel
//   regs_out                         live register contents
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [3:0]                     wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int IDX_W = idx_width(NUM_REGS);

  // One extra bit so the window end cannot wrap at the top of the address space.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(4*NUM_REGS);

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  // Write engine state
  w_state_t              w_state_reg, w_state_next;
  logic                  aw_held_reg, aw_held_next;
  logic                  w_held_reg, w_held_next;
  logic [ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [3:0]            wstrb_reg, wstrb_next;
  logic                  awready_reg, awready_next;
  logic                  wready_reg, wready_next;
  logic                  bvalid_reg, bvalid_next;
  logic [1:0]            bresp_reg, bresp_next;

  // Read engine state
  r_state_t              r_state_reg, r_state_next;
  logic                  arready_reg, arready_next;
  logic                  rvalid_reg, rvalid_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]            rresp_reg, rresp_next;

  // Register bank ports
  logic                  bank_we;
  logic [IDX_W-1:0]      bank_widx;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [3:0]            bank_wstrb;
  logic [IDX_W-1:0]      bank_ridx;
  logic [DATA_WIDTH-1:0] bank_rdata;

  // Effective write fields: latched copy if that channel was taken earlier,
  // otherwise the live bus value (same-cycle handshake).
  logic [ADDR_WIDTH-1:0] cur_awaddr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [3:0]            cur_wstrb;
  logic                  aw_hs, w_hs, ar_hs;
  logic                  aw_have, w_have;

  assign aw_hs      = awvalid && awready_reg;
  assign w_hs       = wvalid && wready_reg;
  assign ar_hs      = arvalid && arready_reg;
  assign aw_have    = aw_held_reg || aw_hs;
  assign w_have     = w_held_reg || w_hs;
  assign cur_awaddr = aw_held_reg ? awaddr_reg : awaddr;
  assign cur_wdata  = w_held_reg ? wdata_reg : wdata;
  assign cur_wstrb  = w_held_reg ? wstrb_reg : wstrb;

  always_comb begin
    w_state_next = w_state_reg;
    aw_held_next = aw_held_reg;
    w_held_next  = w_held_reg;
    awaddr_next  = awaddr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    awready_next = awready_reg;
    wready_next  = wready_reg;
    bvalid_next  = bvalid_reg;
    bresp_next   = bresp_reg;
    bank_we      = 1'b0;
    bank_widx    = cur_awaddr[IDX_W+1:2];
    bank_wdata   = cur_wdata;
    bank_wstrb   = cur_wstrb;

    case (w_state_reg)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_next = 1'b1;
          awaddr_next  = awaddr;
        end
        if (w_hs) begin
          w_held_next = 1'b1;
          wdata_next  = wdata;
          wstrb_next  = wstrb;
        end
        if (aw_have && w_have) begin
          // Out-of-window writes leave every register untouched.
          bank_we      = in_window(cur_awaddr);
          bresp_next   = in_window(cur_awaddr) ? RESP_OKAY : RESP_SLVERR;
          bvalid_next  = 1'b1;
          awready_next = 1'b0;
          wready_next  = 1'b0;
          w_state_next = W_RESP;
        end else begin
          awready_next = !aw_have;
          wready_next  = !w_have;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_next  = 1'b0;
          aw_held_next = 1'b0;
          w_held_next  = 1'b0;
          awready_next = 1'b1;
          wready_next  = 1'b1;
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign bank_ridx = araddr[IDX_W+1:2];

  always_comb begin
    r_state_next = r_state_reg;
    arready_next = arready_reg;
    rvalid_next  = rvalid_reg;
    rdata_next   = rdata_reg;
    rresp_next   = rresp_reg;

    case (r_state_reg)
      R_IDLE: begin
        arready_next = 1'b1;
        if (ar_hs) begin
          arready_next = 1'b0;
          rvalid_next  = 1'b1;
          if (in_window(araddr)) begin
            rdata_next = bank_rdata;
            rresp_next = RESP_OKAY;
          end else begin
            rdata_next = '0;
            rresp_next = RESP_SLVERR;
          end
          r_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_next  = 1'b0;
          arready_next = 1'b1;
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_state_reg <= W_IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= '0;
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      aw_held_reg <= aw_held_next;
      w_held_reg  <= w_held_next;
      awaddr_reg  <= awaddr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
      r_state_reg <= r_state_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      rdata_reg   <= rdata_next;
      rresp_reg   <= rresp_next;
    end
  end

  axi_lite_reg_bank #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (bank_we),
    .widx     (bank_widx),
    .wdata    (bank_wdata),
    .wstrb    (bank_wstrb),
    .ridx     (bank_ridx),
    .rdata    (bank_rdata),
    .regs_out (regs_out)
  );

  assign awready = awready_reg;
  assign wready  = wready_reg;
  assign bvalid  = bvalid_reg;
  assign bresp   = bresp_reg;
  assign arready = arready_reg;
  assign rvalid  = rvalid_reg;
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;

endmodule
